// File: rtl/i2c_pkg.sv
// i2c_pkg: FSM states and line-event encodings shared by the I2C slave files
package i2c_pkg;
  typedef enum logic [3:0] {IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK} state_e;
  typedef enum logic [1:0] {EDGE_NONE, EDGE_RISE, EDGE_FALL} edge_e;
  typedef enum logic [1:0] {BUS_NONE, BUS_START, BUS_STOP} bus_cond_e;
  localparam logic [3:0] BYTE_BITS = 4'd8;
endpackage

// File: rtl/i2c_sync_edge.sv
// i2c_sync_edge: multi-flop synchronizer with rise/fall classification for one bus line
module i2c_sync_edge
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  d_i,
  output logic  q_o,
  output edge_e edge_o
);
  logic [SYNC_STAGES:0] sync_q;
  always_ff @(posedge clk) sync_q <= rst ? '1 : {sync_q[SYNC_STAGES-1:0], d_i};
  assign q_o = sync_q[SYNC_STAGES-1];
  assign edge_o = (q_o == sync_q[SYNC_STAGES]) ? EDGE_NONE : q_o ? EDGE_RISE : EDGE_FALL;
endmodule

// File: rtl/i2c_slave_regif.sv
// i2c_slave_regif: I2C slave translating bus transfers into register-port writes and reads
module i2c_slave_regif
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  input  logic [6:0] i_slave_addr,
  input  logic [7:0] i_rd_data,
  output logic       o_wr_en,
  output logic [7:0] o_reg_addr,
  output logic [7:0] o_wr_data,
  output logic       o_rd_done,
  output logic       sda_out_en
);
  logic scl_s, sda_s, wr_en_q, rd_done_q, oe_q, sda_q;
  edge_e scl_e, sda_e;
  bus_cond_e cond;
  state_e state_q;
  logic [3:0] cnt_q;
  logic [7:0] shift_q, reg_addr_q, wr_data_q;
  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl (.clk(clk), .rst(rst), .d_i(scl), .q_o(scl_s), .edge_o(scl_e));
  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda (.clk(clk), .rst(rst), .d_i(sda), .q_o(sda_s), .edge_o(sda_e));
  // our own SDA transitions must never look like START/STOP
  always_comb cond = (!scl_s || oe_q) ? BUS_NONE : (sda_e == EDGE_FALL) ? BUS_START : (sda_e == EDGE_RISE) ? BUS_STOP : BUS_NONE;
  always_ff @(posedge clk) begin
    wr_en_q <= 1'b0;
    rd_done_q <= 1'b0;
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      shift_q <= '0;
      reg_addr_q <= '0;
      wr_data_q <= '0;
      oe_q <= 1'b0;
      sda_q <= 1'b0;
    end else if (cond == BUS_START) begin
      state_q <= ADDR;
      cnt_q <= '0;
      oe_q <= 1'b0;
    end else if (cond == BUS_STOP) begin
      state_q <= IDLE;
      oe_q <= 1'b0;
    end else if (scl_e == EDGE_RISE) begin
      case (state_q)
        ADDR, REG, WDATA: begin
          shift_q <= {shift_q[6:0], sda_s};
          cnt_q <= cnt_q + 4'd1;
          if (state_q == WDATA && cnt_q == 4'd7) begin
            wr_data_q <= {shift_q[6:0], sda_s};
            wr_en_q <= 1'b1;
          end
        end
        RDATA: cnt_q <= cnt_q + 4'd1;
        RDATA_ACK: begin
          rd_done_q <= 1'b1;
          reg_addr_q <= reg_addr_q + 8'd1;
          cnt_q <= 4'd1;
          state_q <= sda_s ? IDLE : RDATA_ACK;
        end
        default: ;
      endcase
    end else if (scl_e == EDGE_FALL) begin
      case (state_q)
        ADDR: if (cnt_q == BYTE_BITS) begin
          cnt_q <= '0;
          state_q <= (shift_q[7:1] == i_slave_addr) ? ADDR_ACK : IDLE;
          oe_q <= shift_q[7:1] == i_slave_addr;
          sda_q <= 1'b0;
        end
        ADDR_ACK: begin
          state_q <= shift_q[0] ? RDATA : REG;
          oe_q <= shift_q[0];
          shift_q <= i_rd_data;
          sda_q <= i_rd_data[7];
        end
        REG, WDATA: if (cnt_q == BYTE_BITS) begin
          cnt_q <= '0;
          state_q <= (state_q == REG) ? REG_ACK : WDATA_ACK;
          reg_addr_q <= (state_q == REG) ? shift_q : reg_addr_q;
          oe_q <= 1'b1;
          sda_q <= 1'b0;
        end
        REG_ACK, WDATA_ACK: begin
          state_q <= WDATA;
          oe_q <= 1'b0;
          reg_addr_q <= reg_addr_q + {7'd0, state_q == WDATA_ACK};
        end
        RDATA: if (cnt_q == BYTE_BITS) begin
          cnt_q <= '0;
          oe_q <= 1'b0;
          state_q <= RDATA_ACK;
        end else sda_q <= shift_q[~cnt_q[2:0]];
        RDATA_ACK: if (cnt_q == 4'd1) begin
          cnt_q <= '0;
          state_q <= RDATA;
          oe_q <= 1'b1;
          shift_q <= i_rd_data;
          sda_q <= i_rd_data[7];
        end
        default: ;
      endcase
    end
  end
  assign sda = oe_q ? sda_q : 1'bz;
  assign sda_out_en = oe_q;
  assign o_wr_en = wr_en_q;
  assign o_rd_done = rd_done_q;
  assign o_reg_addr = reg_addr_q;
  assign o_wr_data = wr_data_q;
endmodule

// File: tb/tb_i2c_slave_regif.sv
// tb_i2c_slave_regif: directed self-checking bench driving an open-drain I2C master model
module tb_i2c_slave_regif;
  localparam int Q = 30;
  typedef struct {
    logic [7:0] a;
    logic [7:0] off;
    logic [7:0] dat;
    logic       ack;
  } wr_vec_t;
  logic clk = 1'b0, rst = 1'b1, scl = 1'b1, m_sda = 1'b1, use_model = 1'b0;
  wire sda;
  logic [6:0] i_slave_addr = 7'h05;
  logic [7:0] i_rd_data, o_reg_addr, o_wr_data;
  logic o_wr_en, o_rd_done, sda_out_en;
  int n_chk = 0, n_fail = 0, wr_cnt = 0, rd_cnt = 0, oe_cyc = 0;
  logic [7:0] wr_addr_log [16];
  logic [7:0] wr_data_log [16];
  assign sda = m_sda ? 1'bz : 1'b0;
  pullup (sda);
  assign i_rd_data = use_model ? (o_reg_addr ^ 8'h5A) : 8'h13;
  always #5 clk = ~clk;
  i2c_slave_regif #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda), .i_slave_addr(i_slave_addr), .i_rd_data(i_rd_data),
    .o_wr_en(o_wr_en), .o_reg_addr(o_reg_addr), .o_wr_data(o_wr_data), .o_rd_done(o_rd_done), .sda_out_en(sda_out_en)
  );
  always @(negedge clk) begin
    if (sda_out_en) oe_cyc++;
    if (o_rd_done) rd_cnt++;
    if (o_wr_en) begin
      wr_addr_log[wr_cnt % 16] = o_reg_addr;
      wr_data_log[wr_cnt % 16] = o_wr_data;
      wr_cnt++;
    end
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic clk_bit(input logic b, output logic s);
    m_sda = b; #Q; scl = 1'b1; #Q; s = sda; #Q; scl = 1'b0; #Q;
  endtask
  task automatic start_c();
    m_sda = 1'b1; #Q; scl = 1'b1; #Q; m_sda = 1'b0; #Q; scl = 1'b0; #Q;
  endtask
  task automatic stop_c();
    m_sda = 1'b0; #Q; scl = 1'b1; #Q; m_sda = 1'b1; #Q;
  endtask
  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, ack);
  endtask
  task automatic recv_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      d[i] = s;
    end
    clk_bit(mack, s);
  endtask
  initial begin
    wr_vec_t wv [3];
    logic a0, a1, a2, a3, s;
    logic [7:0] d0, d1;
    int wb, rb, ob;
    wv[0] = '{8'h0A, 8'hAA, 8'hAA, 1'b1};
    wv[1] = '{8'h0C, 8'h12, 8'h34, 1'b0};
    wv[2] = '{8'h0A, 8'h3C, 8'h5A, 1'b1};
    #40;
    check("reset_outputs", {o_wr_en, o_rd_done, sda_out_en, o_reg_addr, o_wr_data}, 0);
    rst = 1'b0;
    #(4*Q);
    for (int k = 0; k < 3; k++) begin
      wb = wr_cnt; ob = oe_cyc;
      start_c(); send_byte(wv[k].a, a0); send_byte(wv[k].off, a1); send_byte(wv[k].dat, a2); stop_c(); #(4*Q);
      check("addr_ack", a0, !wv[k].ack);
      check("off_ack", a1, !wv[k].ack);
      check("data_ack", a2, !wv[k].ack);
      check("wr_count", wr_cnt - wb, wv[k].ack);
      if (wv[k].ack) begin
        check("wr_addr", wr_addr_log[wb % 16], wv[k].off);
        check("wr_data", wr_data_log[wb % 16], wv[k].dat);
      end else check("passive_oe", oe_cyc - ob, 0);
    end
    wb = wr_cnt; rb = rd_cnt;
    start_c(); send_byte(8'h0A, a0); send_byte(8'hD3, a1); start_c(); send_byte(8'h0B, a2);
    check("rd_reg_addr", o_reg_addr, 8'hD3);
    recv_byte(1'b1, d0); stop_c(); #(4*Q);
    check("rd_acks", {a0, a1, a2}, 0);
    check("rd_data", d0, 8'h13);
    check("rd_done_count", rd_cnt - rb, 1);
    check("rd_no_write", wr_cnt - wb, 0);
    check("rd_released", sda_out_en, 0);
    check("rd_addr_inc", o_reg_addr, 8'hD4);
    wb = wr_cnt;
    start_c(); send_byte(8'h0A, a0); send_byte(8'hFF, a1); send_byte(8'h11, a2); send_byte(8'h22, a3); stop_c(); #(4*Q);
    check("burst_acks", {a0, a1, a2, a3}, 0);
    check("burst_wr_count", wr_cnt - wb, 2);
    check("burst_addr0", wr_addr_log[wb % 16], 8'hFF);
    check("burst_data0", wr_data_log[wb % 16], 8'h11);
    check("burst_addr1_wrap", wr_addr_log[(wb + 1) % 16], 8'h00);
    check("burst_data1", wr_data_log[(wb + 1) % 16], 8'h22);
    use_model = 1'b1; rb = rd_cnt;
    start_c(); send_byte(8'h0A, a0); send_byte(8'h40, a1); start_c(); send_byte(8'h0B, a2);
    recv_byte(1'b0, d0); recv_byte(1'b1, d1); stop_c(); #(4*Q);
    check("bread_acks", {a0, a1, a2}, 0);
    check("bread_byte0", d0, 8'h1A);
    check("bread_byte1", d1, 8'h1B);
    check("bread_done_count", rd_cnt - rb, 2);
    check("bread_addr", o_reg_addr, 8'h42);
    use_model = 1'b0; rb = rd_cnt; wb = wr_cnt;
    start_c(); send_byte(8'h0A, a0); send_byte(8'h55, a1); start_c(); send_byte(8'h0B, a2);
    for (int i = 0; i < 3; i++) clk_bit(1'b1, s);
    #Q;
    check("pre_rst_oe", sda_out_en, 1);
    rst = 1'b1; #10;
    check("mid_rst_outputs", {o_wr_en, o_rd_done, sda_out_en, o_reg_addr, o_wr_data}, 0);
    #10; rst = 1'b0; #(2*Q);
    stop_c(); #(4*Q);
    check("rst_no_strobes", (rd_cnt - rb) + (wr_cnt - wb), 0);
    start_c(); send_byte(8'h0A, a0); send_byte(8'h07, a1); send_byte(8'h99, a2); stop_c(); #(4*Q);
    check("post_rst_acks", {a0, a1, a2}, 0);
    check("post_rst_wr_count", wr_cnt - wb, 1);
    check("post_rst_wr_addr", wr_addr_log[wb % 16], 8'h07);
    check("post_rst_wr_data", wr_data_log[wb % 16], 8'h99);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
